dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Control stage directly upstream and downstream of one DSP48A1 slice.
- Accepts a valid/ready stream of unsigned 18-bit (a, b) pairs and drives the slice's A, B and OPMODE inputs so the slice accumulates sum(a*b) over a fixed-length frame.
- Reads back P and presents one 48-bit result per frame on a valid/ready output.
- Tracks the slice's pipeline latency with a tag delay line, so the slice keeps all CE pins tied high.

Parameters:
- LEN, 8: products per frame, range 1..4096 (no 48-bit overflow).
- MULT_LAT, 2: edges from dsp_a/dsp_b update to product in M register (A0REG+A1REG+MREG of the slice).
- OPM_LAT, 1: OPMODE register depth of the slice (0 or 1). Requirement: MULT_LAT >= OPM_LAT.
- P_LAT, 1: P register depth of the slice (must be 1; accumulation uses Z=P feedback).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- s_valid  in  1  input pair valid.
- s_ready  out  1  sequencer accepts the pair this cycle.
- s_a  in  18  multiplicand.
- s_b  in  18  multiplier.
- m_valid  out  1  frame result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  48  frame sum.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B (B_INPUT="DIRECT").
- dsp_opmode  out  8  to slice OPMODE.
- dsp_p  in  48  from slice P.

Behaviour:
- Transfer occurs on an edge where s_valid & s_ready, or m_valid & m_ready.
- Reset values: state=ACCUM, count=0, tag line cleared, dsp_a=0, dsp_b=0, dsp_opmode=8'h00, m_valid=0, m_data=0. s_ready=0 while RST is high. The integrator ties the slice resets to the same RST.
- OPMODE codes:
  - FIRST=8'h01 (X=M, Z=0).
  - ACC=8'h09 (X=M, Z=P).
  - HOLD=8'h08 (X=0, Z=P).
  - Bits 4..7 are always 0: no pre-adder, carry 0, post-add.
- FSM states:
  - ACCUM: s_ready=1. On each accept, register s_a/s_b into dsp_a/dsp_b on that edge (edge k), push tag {valid=1, first=(count==0), last=(count==LEN-1)}, and increment count. On the accept of the last pair, reset count to 0 and go to DRAIN. Non-accept cycles push tag valid=0, and dsp_a/dsp_b hold.
  - DRAIN: s_ready=0. Tags keep shifting with valid=0. When the last tag reaches the capture point, go to RESULT.
  - RESULT: m_valid=1 and m_data stable. On an m_ready transfer go to ACCUM; m_valid drops on that edge.
- Timing:
  - The tag for accept edge k sets dsp_opmode at edge k+MULT_LAT-OPM_LAT, so the slice's OPMODE register holds it during edge k+MULT_LAT..k+MULT_LAT+1.
  - Tag valid & first gives FIRST; valid & ~first gives ACC; otherwise HOLD. Bubbles therefore leave P unchanged.
  - P holds the frame sum after edge k_last+MULT_LAT+P_LAT. It is captured into m_data with m_valid=1 on the following edge. With defaults, m_valid rises 4 edges after the last accept.
- Arithmetic: unsigned, matching the slice multiplier. The sum is exact for LEN<=4096.
- LEN=1: the single tag is both first and last, so OPMODE=FIRST.
- Back-to-back frames: no overlap. A new frame starts only after the result transfer. The first term uses Z=0, so the previous sum is discarded.
- m_ready high at the same edge m_valid rises: result transfers on the next edge (one cycle of m_valid minimum).
- RST mid-frame: the partial frame is discarded and no result is produced. The first post-reset pair begins a new frame.

Optional Feature:
- Macro: DSP_MAC_ROUND_BIAS_EN.
- When defined:
  - Adds port rnd_bias in 48 (quasi-static) and output dsp_c out 48 (=rnd_bias) to slice C.
  - FIRST code becomes 8'h0D (X=M, Z=C), so the frame sum includes rnd_bias once.
- When undefined: neither port exists, and FIRST=8'h01.

Decomposition:
- Package dsp_seq_pkg holds:
  - OPMODE constants OPM_FIRST, OPM_FIRST_C, OPM_ACC, OPM_HOLD.
  - State enum {ACCUM, DRAIN, RESULT}.
  - Tag struct {valid, first, last}.
- Sub-module dsp_tag_pipe: parameterised-depth shift register of tags with synchronous clear, with taps at depth MULT_LAT-OPM_LAT (OPMODE) and MULT_LAT+P_LAT (capture).

Test Plan:
All scenarios use the slice at default parameters (A0REG=0, A1REG=1, MREG=1, PREG=1, OPMODEREG=1).
- LEN=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> m_data=100. m_valid rises 4 edges after the 4th accept; dsp_opmode sequence 01,09,09,09 then 08.
- LEN=4, all pairs (0x3FFFF,0x3FFFF) -> m_data=48'h3F_FFE0_0004.
- Same frame as scenario 1 with s_valid low 3 cycles between pairs 2 and 3 -> m_data=100; dsp_opmode=08 during the gap taps.
- m_ready held low 10 cycles after m_valid -> m_data stable, s_ready=0 throughout. Second frame (2,2)x4 after release -> m_data=16, with no carry-over from the first frame.
- RST pulsed after 2 pairs -> no m_valid. Next frame (1,1)x4 -> m_data=4.
- With DSP_MAC_ROUND_BIAS_EN, rnd_bias=0x8000, scenario 1 frame -> m_data=32868 and first code 0D.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: OPMODE codes, sequencer states and pipeline tag type for dsp_mac_sequencer.
package dsp_seq_pkg;
    localparam logic [7:0] OPM_FIRST   = 8'h01;
    localparam logic [7:0] OPM_FIRST_C = 8'h0D;
    localparam logic [7:0] OPM_ACC     = 8'h09;
    localparam logic [7:0] OPM_HOLD    = 8'h08;
    typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} state_t;
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;
endpackage

// File: rtl/dsp_tag_pipe.sv
// dsp_tag_pipe: tag delay line mirroring the slice pipeline; taps for OPMODE drive and P capture.
module dsp_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int OPM_TAP = 1
) (
    input  logic CLK,
    input  logic RST,
    input  tag_t in_tag,
    output logic opm_valid,
    output logic opm_first,
    output logic cap_last
);
    tag_t stage [DEPTH];
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage <= '{default: '0};
        end else begin
            stage[0] <= in_tag;
            for (int i = DEPTH - 1; i > 0; i--) stage[i] <= stage[i-1];
        end
    end
    // A zero-depth OPMODE tap means the slice registers OPMODE as late as A/B, so drive it from the push itself.
    generate
        if (OPM_TAP == 0) begin : g_opm_direct
            assign opm_valid = in_tag.valid;
            assign opm_first = in_tag.first;
        end else begin : g_opm_tap
            assign opm_valid = stage[OPM_TAP-1].valid;
            assign opm_first = stage[OPM_TAP-1].first;
        end
    endgenerate
    assign cap_last = stage[DEPTH-1].valid && stage[DEPTH-1].last;
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1 slice to accumulate sum(a*b) per LEN-pair frame, one result per frame.
// Optional DSP_MAC_ROUND_BIAS_EN adds a C-port bias folded into the first term of every frame.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN      = 8,
    parameter int MULT_LAT = 2,
    parameter int OPM_LAT  = 1,
    parameter int P_LAT    = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
`ifdef DSP_MAC_ROUND_BIAS_EN
    input  logic [47:0] rnd_bias,
    output logic [47:0] dsp_c,
`endif
    input  logic [47:0] dsp_p
);
    localparam int CW = $clog2(LEN + 1);
`ifdef DSP_MAC_ROUND_BIAS_EN
    localparam logic [7:0] FIRST_CODE = OPM_FIRST_C;
    assign dsp_c = rnd_bias;
`else
    localparam logic [7:0] FIRST_CODE = OPM_FIRST;
`endif
    state_t          state, next_state;
    logic [CW-1:0]   count;
    tag_t            push_tag;
    logic            accept, opm_valid, opm_first, cap_last;
    assign s_ready  = (state == ACCUM) && !RST;
    assign m_valid  = (state == RESULT);
    assign accept   = s_valid && s_ready;
    assign push_tag = {accept, accept && (count == '0), accept && (count == CW'(LEN - 1))};
    // Capture sits one edge past the P register so m_data samples the settled frame sum.
    dsp_tag_pipe #(
        .DEPTH  (MULT_LAT + P_LAT + 1),
        .OPM_TAP(MULT_LAT - OPM_LAT)
    ) u_tags (
        .CLK      (CLK),
        .RST      (RST),
        .in_tag   (push_tag),
        .opm_valid(opm_valid),
        .opm_first(opm_first),
        .cap_last (cap_last)
    );
    always_ff @(posedge CLK) begin
        if (RST) state <= ACCUM;
        else     state <= next_state;
    end
    always_comb begin
        next_state = state;
        next_state = (state == ACCUM && push_tag.last) ? DRAIN  :
                     (state == DRAIN && cap_last)      ? RESULT :
                     (state == RESULT && m_ready)      ? ACCUM  : state;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            count      <= '0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= 8'h00;
            m_data     <= '0;
        end else begin
            if (accept) begin
                dsp_a <= s_a;
                dsp_b <= s_b;
                count <= push_tag.last ? '0 : count + CW'(1);
            end
            dsp_opmode <= !opm_valid ? OPM_HOLD : opm_first ? FIRST_CODE : OPM_ACC;
            if (state == DRAIN && cap_last) m_data <= dsp_p;
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed frames against a DSP48A1 slice model with a frame-level scoreboard.
module tb_dsp_mac_sequencer;
    localparam int LEN = 4;
    localparam int LAT = 4;
`ifdef DSP_MAC_ROUND_BIAS_EN
    localparam logic [7:0]  FIRST_CODE = 8'h0D;
    localparam logic [47:0] BIAS       = 48'h8000;
`else
    localparam logic [7:0]  FIRST_CODE = 8'h01;
    localparam logic [47:0] BIAS       = 48'h0;
`endif
    logic        CLK = 0, RST = 1, s_valid = 0, m_ready = 0;
    logic [17:0] s_a = 0, s_b = 0;
    logic        s_ready, m_valid;
    logic [47:0] m_data, dsp_p, c_in;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    int          vectors = 0, miscompares = 0;
    logic [7:0]  opm_log [$];
`ifdef DSP_MAC_ROUND_BIAS_EN
    logic [47:0] rnd_bias = BIAS;
    logic [47:0] dsp_c;
    assign c_in = dsp_c;
`else
    assign c_in = 48'h0;
`endif
    dsp_mac_sequencer #(.LEN(LEN)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_opmode(dsp_opmode),
`ifdef DSP_MAC_ROUND_BIAS_EN
        .rnd_bias  (rnd_bias),
        .dsp_c     (dsp_c),
`endif
        .dsp_p     (dsp_p)
    );
    always #5 CLK = ~CLK;
    // Slice at A0REG=0, A1REG=1, MREG=1, PREG=1, OPMODEREG=1, all CE high.
    logic [17:0] a1, b1;
    logic [47:0] m_r, p_r;
    logic [7:0]  opm_r;
    always @(posedge CLK) begin
        if (RST) begin
            a1 <= 0; b1 <= 0; m_r <= 0; p_r <= 0; opm_r <= 0;
        end else begin
            a1    <= dsp_a;
            b1    <= dsp_b;
            m_r   <= 48'(a1) * 48'(b1);
            opm_r <= dsp_opmode;
            p_r   <= (opm_r[1:0] == 2'b01 ? m_r : 48'd0) +
                     (opm_r[3:2] == 2'b10 ? p_r : opm_r[3:2] == 2'b11 ? c_in : 48'd0);
        end
    end
    assign dsp_p = p_r;
    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Frame-level scoreboard: sums accepted products and predicts when the result appears.
    logic        exp_ready = 1, exp_mvalid = 0;
    logic [47:0] exp_mdata = 0, run_sum = 0, pending = 0;
    int          n_acc = 0, wait_cnt = 0;
    always @(negedge CLK) begin
        opm_log.push_back(dsp_opmode);
        check("s_ready", 48'(s_ready), 48'(exp_ready && !RST));
        check("m_valid", 48'(m_valid), 48'(exp_mvalid));
        if (exp_mvalid) check("m_data", m_data, exp_mdata);
        if (RST) begin
            exp_ready = 1; exp_mvalid = 0; run_sum = 0; n_acc = 0; wait_cnt = 0;
        end else begin
            if (exp_mvalid && m_ready) begin
                exp_mvalid = 0;
                exp_ready  = 1;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    exp_mvalid = 1;
                    exp_mdata  = pending;
                end
            end
            if (s_valid && exp_ready) begin
                run_sum = (n_acc == 0 ? BIAS : run_sum) + 48'(s_a) * 48'(s_b);
                n_acc++;
                if (n_acc == LEN) begin
                    pending   = run_sum;
                    n_acc     = 0;
                    exp_ready = 0;
                    wait_cnt  = LAT;
                end
            end
        end
    end
    task automatic send(input logic [17:0] a, input logic [17:0] b);
        int t = 0;
        s_valid = 1; s_a = a; s_b = b;
        @(negedge CLK);
        while (!s_ready && t < 100) begin t++; @(negedge CLK); end
        if (!s_ready) check("send_timeout", 48'(s_ready), 48'd1);
        @(posedge CLK); #1 s_valid = 0;
    endtask
    task automatic recv(input string name, input logic [47:0] exp, input int hold);
        int t = 0;
        @(negedge CLK);
        while (!m_valid && t < 100) begin t++; @(negedge CLK); end
        check({name, "_valid"}, 48'(m_valid), 48'd1);
        check(name, m_data, exp + BIAS);
        if (hold > 0) begin
            repeat (hold) @(posedge CLK);
            @(negedge CLK);
            check({name, "_stable"}, m_data, exp + BIAS);
        end
        if (!m_ready) begin @(posedge CLK); #1 m_ready = 1; end
        @(posedge CLK); #1 m_ready = 0;
    endtask
    task automatic check_opm(input string name, input logic [63:0] seq, input int n);
        int i = 0;
        while (i < opm_log.size() && opm_log[i] != FIRST_CODE) i++;
        check({name, "_first"}, 48'(i < opm_log.size()), 48'd1);
        for (int j = 0; j < n; j++)
            check(name, 48'(i + j < opm_log.size() ? opm_log[i+j] : 8'hxx), 48'(seq[8*(n-1-j) +: 8]));
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100us");
        $fatal(1);
    end
    initial begin
        int n;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_s_ready", 48'(s_ready), 48'd0);
        check("reset_m_valid", 48'(m_valid), 48'd0);
        check("reset_m_data", m_data, 48'd0);
        check("reset_opmode", 48'(dsp_opmode), 48'h00);
        check("reset_dsp_a", 48'(dsp_a), 48'd0);
        @(posedge CLK); #1 RST = 0;
        // Frame 1: back-to-back, latency and OPMODE sequence.
        opm_log.delete();
        send(1, 2); send(3, 4); send(5, 6); send(7, 8);
        n = 0;
        do begin @(posedge CLK); n++; @(negedge CLK); end while (!m_valid && n < 50);
        check("s1_latency", 48'(n), 48'd4);
        recv("s1_sum", 48'd100, 0);
        check_opm("s1_opm", 64'({FIRST_CODE, 8'h09, 8'h09, 8'h09, 8'h08}), 5);
        // Full-scale operands; m_ready already high when m_valid rises.
        m_ready = 1;
        repeat (LEN) send(18'h3FFFF, 18'h3FFFF);
        recv("s2_sum", 48'h3F_FFE0_0004, 0);
        // Three bubbles mid-frame leave P untouched.
        opm_log.delete();
        send(1, 2); send(3, 4);
        repeat (3) @(posedge CLK);
        #1 send(5, 6); send(7, 8);
        recv("s3_sum", 48'd100, 0);
        check_opm("s3_opm", {FIRST_CODE, 8'h09, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09, 8'h08}, 8);
        // Held result, then a fresh frame must not carry over.
        send(1, 2); send(3, 4); send(5, 6); send(7, 8);
        recv("s4_hold", 48'd100, 10);
        repeat (LEN) send(2, 2);
        recv("s4_next", 48'd16, 0);
        // Reset mid-frame discards the partial sum.
        send(9, 9); send(9, 9);
        RST = 1;
        @(posedge CLK); #1 RST = 0;
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        check("s5_no_result", 48'(m_valid), 48'd0);
        @(posedge CLK); #1;
        repeat (LEN) send(1, 1);
        recv("s5_sum", 48'd4, 0);
        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
